// File: rtl/prog_launch_ctrl.sv
// prog_launch_ctrl: launches up to three programs from a fixed start-address
// table. The bench holds Start high and releases it to launch. The decoder
// ends a program with Halt.
// Optional watchdog: define PROG_LAUNCH_WATCHDOG_EN to abort a program whose
// RUN phase lasts WDOG_CYCLES cycles without Halt.
module prog_launch_ctrl #(
  parameter int unsigned    L           = 10,
  parameter int unsigned    NPROG       = 3,
  parameter logic [L-1:0]   PROG0_ADDR  = L'(0),
  parameter logic [L-1:0]   PROG1_ADDR  = L'(189),
  parameter logic [L-1:0]   PROG2_ADDR  = L'(378),
  parameter int unsigned    WDOG_CYCLES = 4096
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Halt,
  output logic         PcLoad,
  output logic [L-1:0] PcLoadAddr,
  output logic         PcStall,
  output logic         Run,
  output logic         Done,
  output logic [1:0]   ProgIdx,
  output logic         Timeout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] LastIdx = 2'(NPROG);

  state_e     state_q, state_d;
  logic [1:0] prog_idx_q, prog_idx_d;
  logic       start_q;
  logic       start_fall;
  logic       wdog_hit;

  assign start_fall = start_q & ~Start;
  assign ProgIdx    = prog_idx_q;

  // State register, program index and Start history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      prog_idx_q <= 2'd0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
      start_q    <= Start;
    end
  end

  // Next-state logic; Halt beats a simultaneous Start because Start is ignored in RUN.
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    unique case (state_q)
      ST_IDLE:  if (Start) state_d = ST_ARMED;
      ST_ARMED: if (start_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN: begin
        if (Halt || wdog_hit) begin
          state_d    = ST_DONE;
          prog_idx_d = prog_idx_q + 2'd1;
        end
      end
      ST_DONE:  if (Start && (prog_idx_q < LastIdx)) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    PcLoad     = 1'b0;
    PcLoadAddr = '0;
    PcStall    = 1'b1;
    Run        = 1'b0;
    Done       = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        PcLoad = 1'b1;
        unique case (prog_idx_q)
          2'd0:    PcLoadAddr = PROG0_ADDR;
          2'd1:    PcLoadAddr = PROG1_ADDR;
          2'd2:    PcLoadAddr = PROG2_ADDR;
          default: PcLoadAddr = '0;
        endcase
      end
      ST_RUN: begin
        Run     = 1'b1;
        PcStall = 1'b0;
      end
      ST_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

`ifdef PROG_LAUNCH_WATCHDOG_EN
  localparam int unsigned     CntW     = L + 4;
  localparam logic [CntW-1:0] WdogLast = CntW'(WDOG_CYCLES - 1);

  logic [CntW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            timeout_q, timeout_d;

  assign wdog_hit = (state_q == ST_RUN) && !Halt && (wdog_cnt_q == WdogLast);
  assign Timeout  = timeout_q;

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Count RUN cycles from LOAD; the flag clears on the next arm.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    timeout_d  = timeout_q;
    if (state_q == ST_LOAD) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
    if (wdog_hit) begin
      timeout_d = 1'b1;
    end else if ((state_d == ST_ARMED) && (state_q != ST_ARMED)) begin
      timeout_d = 1'b0;
    end
  end
`else
  // Without the watchdog only Halt ends RUN, and WDOG_CYCLES has no effect.
  assign wdog_hit = 1'b0;
  assign Timeout  = (WDOG_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

endmodule
